// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade scheduler: level width, period length,
// per-channel FSM encoding and the saturating step helper.
package pwm_pkg;

   localparam int PWM_LEVEL_W = 8;
   localparam int PWM_PERIOD  = 255;

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } fade_state_t;

   // Moves cur one step toward tgt; a 9-bit distance keeps it from overshooting or wrapping.
   function automatic logic [PWM_LEVEL_W-1:0] fade_step(
      input logic [PWM_LEVEL_W-1:0] cur,
      input logic [PWM_LEVEL_W-1:0] tgt,
      input logic [PWM_LEVEL_W-1:0] stp
   );
      logic [PWM_LEVEL_W:0] w_dist;
      if (tgt > cur) begin
         w_dist = {1'b0, tgt} - {1'b0, cur};
         if (w_dist <= {1'b0, stp}) fade_step = tgt;
         else                       fade_step = cur + stp;
      end else begin
         w_dist = {1'b0, cur} - {1'b0, tgt};
         if (w_dist <= {1'b0, stp}) fade_step = tgt;
         else                       fade_step = cur - stp;
      end
   endfunction

endpackage

// File: rtl/pwm_fade_chan.sv
// One fade channel: IDLE/RAMP FSM, period-interval divider and stepping of the
// programmed level toward its target.
module pwm_fade_chan
   import pwm_pkg::*;
(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   i_load,
   input  logic                   i_tick,
   input  logic [PWM_LEVEL_W-1:0] i_tgt,
   input  logic [PWM_LEVEL_W-1:0] i_stp,
   input  logic [PWM_LEVEL_W-1:0] i_div,
   output logic [PWM_LEVEL_W-1:0] o_level,
   output logic                   o_set_level,
   output logic                   o_busy,
   output logic                   o_done
);

   fade_state_t            r_state;
   logic [PWM_LEVEL_W-1:0] r_cur;
   logic [PWM_LEVEL_W-1:0] r_tgt;
   logic [PWM_LEVEL_W-1:0] r_stp;
   logic [PWM_LEVEL_W-1:0] r_div;
   logic [PWM_LEVEL_W-1:0] r_dcnt;
   logic                   r_set_level;
   logic                   r_done;
   logic [PWM_LEVEL_W-1:0] w_next;

   assign w_next = fade_step(r_cur, r_tgt, r_stp);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= IDLE;
         r_cur       <= '0;
         r_tgt       <= '0;
         r_stp       <= '0;
         r_div       <= '0;
         r_dcnt      <= '0;
         r_set_level <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_set_level <= 1'b0;
         r_done      <= 1'b0;
         // A load takes priority over a coincident tick, which is then simply lost.
         if (i_load) begin
            r_tgt  <= i_tgt;
            r_stp  <= i_stp;
            r_div  <= i_div;
            r_dcnt <= i_div;
            if (i_tgt == r_cur) begin
               r_state <= IDLE;
               r_done  <= 1'b1;
            end else if (i_stp == '0) begin
               r_cur       <= i_tgt;
               r_set_level <= 1'b1;
               r_done      <= 1'b1;
               r_state     <= IDLE;
            end else begin
               r_state <= RAMP;
            end
         end else if (r_state == RAMP && i_tick) begin
            if (r_dcnt != '0) begin
               r_dcnt <= r_dcnt - PWM_LEVEL_W'(1);
            end else begin
               r_dcnt      <= r_div;
               r_cur       <= w_next;
               r_set_level <= 1'b1;
               if (w_next == r_tgt) begin
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end
            end
         end
      end
   end

   assign o_level     = r_cur;
   assign o_set_level = r_set_level;
   assign o_busy      = (r_state == RAMP);
   assign o_done      = r_done;

endmodule

// File: rtl/pwm_fade_sched.sv
// Fade scheduler for a bank of PWM channels: shared period tick, config decode
// and one pwm_fade_chan per channel driving pwm_ctrl level/set_level.
module pwm_fade_sched
   import pwm_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int PERIOD = PWM_PERIOD
)(
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          cfg_wr,
   input  logic [2:0]                    cfg_ch,
   input  logic [PWM_LEVEL_W-1:0]        cfg_target,
   input  logic [PWM_LEVEL_W-1:0]        cfg_step,
   input  logic [PWM_LEVEL_W-1:0]        cfg_div,
   output logic [PWM_LEVEL_W*NUM_CH-1:0] level,
   output logic [NUM_CH-1:0]             set_level,
   output logic [NUM_CH-1:0]             busy,
   output logic [NUM_CH-1:0]             done
);

   localparam int PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [PCNT_W-1:0] r_pcnt;
   logic              w_tick;

   // Mirrors the pwm_ctrl counter so steps land on period boundaries.
   assign w_tick = (r_pcnt == PCNT_W'(PERIOD - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       r_pcnt <= '0;
      else if (w_tick) r_pcnt <= '0;
      else             r_pcnt <= r_pcnt + PCNT_W'(1);
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic w_load;
         assign w_load = cfg_wr && (cfg_ch == 3'(gi));

         pwm_fade_chan u_chan (
            .clk         (clk),
            .rstn        (rstn),
            .i_load      (w_load),
            .i_tick      (w_tick),
            .i_tgt       (cfg_target),
            .i_stp       (cfg_step),
            .i_div       (cfg_div),
            .o_level     (level[gi*PWM_LEVEL_W +: PWM_LEVEL_W]),
            .o_set_level (set_level[gi]),
            .o_busy      (busy[gi]),
            .o_done      (done[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_pwm_fade_sched.sv
// Bench for pwm_fade_sched: directed scenarios plus random config traffic,
// checked every cycle against a behavioural model of the fade rules.
module tb_pwm_fade_sched;

   localparam int NUM_CH = 4;
   localparam int PERIOD = 255;

   logic                  clk = 1'b0;
   logic                  rstn = 1'b0;
   logic                  cfg_wr = 1'b0;
   logic [2:0]            cfg_ch = '0;
   logic [7:0]            cfg_target = '0;
   logic [7:0]            cfg_step = '0;
   logic [7:0]            cfg_div = '0;
   logic [8*NUM_CH-1:0]   level;
   logic [NUM_CH-1:0]     set_level;
   logic [NUM_CH-1:0]     busy;
   logic [NUM_CH-1:0]     done;

   int checks = 0;
   int errors = 0;
   int tb_cyc = 0;
   int wr_cyc = 0;

   always #5 clk = ~clk;

   pwm_fade_sched #(.NUM_CH(NUM_CH), .PERIOD(PERIOD)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .cfg_wr     (cfg_wr),
      .cfg_ch     (cfg_ch),
      .cfg_target (cfg_target),
      .cfg_step   (cfg_step),
      .cfg_div    (cfg_div),
      .level      (level),
      .set_level  (set_level),
      .busy       (busy),
      .done       (done)
   );

   // ---------------- behavioural model ----------------
   int     m_cur  [NUM_CH];
   int     m_tgt  [NUM_CH];
   int     m_stp  [NUM_CH];
   int     m_div  [NUM_CH];
   int     m_ticks[NUM_CH];
   bit     m_ramp [NUM_CH];
   bit     m_set  [NUM_CH];
   bit     m_done [NUM_CH];
   longint m_cyc;

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_cur[c] = 0; m_tgt[c] = 0; m_stp[c] = 0; m_div[c] = 0;
         m_ticks[c] = 0; m_ramp[c] = 0; m_set[c] = 0; m_done[c] = 0;
      end
      m_cyc = 0;
   endtask

   task automatic model_clock();
      bit tick;
      tick = ((m_cyc % PERIOD) == PERIOD - 1);
      for (int c = 0; c < NUM_CH; c++) begin
         m_set[c]  = 0;
         m_done[c] = 0;
         if (cfg_wr && int'(cfg_ch) == c) begin
            m_tgt[c] = int'(cfg_target);
            m_stp[c] = int'(cfg_step);
            m_div[c] = int'(cfg_div);
            m_ticks[c] = 0;
            if (m_tgt[c] == m_cur[c]) begin
               m_ramp[c] = 0; m_done[c] = 1;
            end else if (m_stp[c] == 0) begin
               m_cur[c] = m_tgt[c]; m_set[c] = 1; m_done[c] = 1; m_ramp[c] = 0;
            end else begin
               m_ramp[c] = 1;
            end
         end else if (m_ramp[c] && tick) begin
            m_ticks[c]++;
            if (m_ticks[c] == m_div[c] + 1) begin
               m_ticks[c] = 0;
               if (m_tgt[c] > m_cur[c])
                  m_cur[c] = (m_cur[c] + m_stp[c] > m_tgt[c]) ? m_tgt[c] : m_cur[c] + m_stp[c];
               else
                  m_cur[c] = (m_cur[c] - m_stp[c] < m_tgt[c]) ? m_tgt[c] : m_cur[c] - m_stp[c];
               m_set[c] = 1;
               if (m_cur[c] == m_tgt[c]) begin
                  m_done[c] = 1; m_ramp[c] = 0;
               end
            end
         end
      end
      m_cyc++;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) model_reset();
         else       model_clock();
      end
   end

   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   initial begin
      logic [8*NUM_CH-1:0] e_level;
      logic [NUM_CH-1:0]   e_set, e_busy, e_done;
      forever begin
         @(negedge clk);
         for (int c = 0; c < NUM_CH; c++) begin
            e_level[c*8 +: 8] = 8'(m_cur[c]);
            e_set[c]  = m_set[c];
            e_busy[c] = m_ramp[c];
            e_done[c] = m_done[c];
         end
         checks++;
         if (level !== e_level || set_level !== e_set || busy !== e_busy || done !== e_done) begin
            errors++;
            $display("FAIL cycle_compare t=%0t: got level=%h set=%b busy=%b done=%b expected level=%h set=%b busy=%b done=%b",
                     $time, level, set_level, busy, done, e_level, e_set, e_busy, e_done);
         end
      end
   end

   // Event log of what the DUT actually emitted, used by the literal scenario checks.
   typedef struct { int ch; int lvl; int cyc; } ev_t;
   ev_t ev_q[$];
   int  done_cnt[NUM_CH];

   initial begin
      forever begin
         @(negedge clk);
         for (int c = 0; c < NUM_CH; c++) begin
            if (rstn && set_level[c]) ev_q.push_back('{c, int'(level[c*8 +: 8]), tb_cyc});
            if (rstn && done[c]) done_cnt[c]++;
         end
      end
   end

   task automatic clear_log();
      ev_q.delete();
      for (int c = 0; c < NUM_CH; c++) done_cnt[c] = 0;
   endtask

   task automatic check_levels(input string name, input int ch, input int exp[8], input int n);
      int got[$];
      got = {};
      foreach (ev_q[i]) if (ev_q[i].ch == ch) got.push_back(ev_q[i].lvl);
      chk({name, "_count"}, got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++)
         chk($sformatf("%s_%0d", name, i), got[i], exp[i]);
   endtask

   function automatic int ev_cyc(input int ch, input int idx);
      int k;
      k = 0;
      foreach (ev_q[i]) begin
         if (ev_q[i].ch == ch) begin
            if (k == idx) return ev_q[i].cyc;
            k++;
         end
      end
      return -1;
   endfunction

   task automatic cfg(input int ch, input int tgt, input int stp, input int div, input bit on_tick);
      int g;
      g = 0;
      @(negedge clk);
      if (on_tick)
         while ((m_cyc % PERIOD) != PERIOD - 1 && g < 2 * PERIOD) begin
            @(negedge clk);
            g++;
         end
      cfg_wr = 1'b1; cfg_ch = 3'(ch); cfg_target = 8'(tgt); cfg_step = 8'(stp); cfg_div = 8'(div);
      $display("cfg t=%0t ch=%0d target=%0d step=%0d div=%0d on_tick=%0d", $time, ch, tgt, stp, div, on_tick);
      @(negedge clk);
      cfg_wr = 1'b0;
      wr_cyc = tb_cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int e[8];
      int guard;
      int rel_cyc;
      int ch, tgt, stp;

      // 1: reset and long idle
      idle(3);
      chk("reset_level", int'(level), 0);
      chk("reset_busy", int'(busy), 0);
      rstn = 1'b1;
      clear_log();
      idle(1000);
      chk("idle_events", ev_q.size(), 0);
      chk("idle_done", done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3], 0);

      // 2: ch0 0 -> 100, step 30, every period
      clear_log();
      cfg(0, 100, 30, 0, 0);
      chk("s2_busy_start", int'(busy[0]), 1);
      idle(4 * PERIOD + 10);
      e = '{30, 60, 90, 100, 0, 0, 0, 0};
      check_levels("s2_levels", 0, e, 4);
      chk("s2_done_count", done_cnt[0], 1);
      chk("s2_busy_end", int'(busy[0]), 0);

      // 3: ch1 preload 200 then fade down to 50 every third period
      cfg(1, 200, 0, 0, 0);
      idle(3);
      clear_log();
      cfg(1, 50, 60, 2, 0);
      idle(9 * PERIOD + 20);
      e = '{140, 80, 50, 0, 0, 0, 0, 0};
      check_levels("s3_levels", 1, e, 3);
      chk("s3_spacing_a", ev_cyc(1, 1) - ev_cyc(1, 0), 3 * PERIOD);
      chk("s3_spacing_b", ev_cyc(1, 2) - ev_cyc(1, 1), 3 * PERIOD);
      chk("s3_first_step_window", int'(ev_cyc(1, 0) - wr_cyc > 2 * PERIOD && ev_cyc(1, 0) - wr_cyc <= 3 * PERIOD), 1);

      // 4: ch2 jump to full scale, then repeat
      clear_log();
      cfg(2, 255, 0, 0, 0);
      chk("s4_level", int'(level[23:16]), 255);
      chk("s4_set", int'(set_level[2]), 1);
      chk("s4_done", int'(done[2]), 1);
      chk("s4_busy", int'(busy[2]), 0);
      cfg(2, 255, 0, 0, 0);
      chk("s4_repeat_done", int'(done[2]), 1);
      chk("s4_repeat_set", int'(set_level[2]), 0);

      // 5: retarget mid-ramp on a tick cycle
      cfg(0, 0, 0, 0, 0);
      clear_log();
      cfg(0, 200, 10, 0, 0);
      guard = 0;
      while (m_cur[0] != 40 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      chk("s5_reach40", m_cur[0], 40);
      cfg(0, 0, 20, 0, 1);
      idle(3 * PERIOD);
      e = '{10, 20, 30, 40, 20, 0, 0, 0};
      check_levels("s5_levels", 0, e, 6);
      chk("s5_done_count", done_cnt[0], 1);
      chk("s5_tick_skipped", ev_cyc(0, 4) - wr_cyc, PERIOD);

      // 6: async reset mid-ramp on every channel
      cfg(0, 250, 1, 0, 0);
      cfg(1, 0, 1, 0, 0);
      cfg(2, 0, 1, 1, 0);
      cfg(3, 200, 5, 0, 0);
      idle(600);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("s6_async_level", int'(level), 0);
      chk("s6_async_busy", int'(busy), 0);
      chk("s6_async_set", int'(set_level), 0);
      chk("s6_async_done", int'(done), 0);
      idle(4);
      rstn = 1'b1;
      rel_cyc = tb_cyc;
      clear_log();
      cfg(7, 123, 0, 0, 0);
      idle(5);
      chk("s6_bad_ch_events", ev_q.size(), 0);
      chk("s6_bad_ch_done", done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3], 0);
      cfg(3, 10, 10, 0, 0);
      idle(PERIOD);
      chk("s6_restart_tick", ev_cyc(3, 0) - rel_cyc, PERIOD);

      // 7: random configuration traffic
      for (int it = 0; it < 40; it++) begin
         ch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
         tgt = int'($urandom_range(0, 255));
         if (ch < NUM_CH && $urandom_range(0, 7) == 0) tgt = m_cur[ch];
         stp = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 90));
         cfg(ch, tgt, stp, int'($urandom_range(0, 2)), bit'($urandom_range(0, 3) == 0));
         idle(int'($urandom_range(0, 600)));
      end
      idle(3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
